alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single ALU_top instance between two requesters: req 0 is CU execute, req 1 is the branch/compare path.
//  Accepts ops over valid/ready, issues one op at a time with a 1-cycle dat_ready pulse, and waits for ALU_ready.
//  Returns result and flags to the granted requester over valid/ready. Round-robin grant; watchdog on a hung ALU.
// PARAMETERS
//  TIMEOUT_CYCLES  8   max cycles in WAIT before an error response (must be >= 4)
// PORTS
//  soc_clk          in   1   clock
//  reset            in   1   reset, synchronous, active-high
//  req_valid        in   2   per-requester op valid; hold until req_ready
//  req_ready        out  2   one-hot accept pulse, IDLE only
//  req_op0/req_op1  in   6   Instruction_from_CU code per requester
//  req_a0/req_a1    in   32  operand 1 per requester
//  req_b0/req_b1    in   32  operand 2 per requester
//  resp_valid       out  2   one-hot response valid, held until resp_ready
//  resp_ready       in   2   per-requester response accept
//  resp_out         out  32  captured ALU_out
//  resp_flags       out  4   {err,con_met,zero,overflow}; err = ALU_err | timeout
//  alu_dat_ready    out  1   to ALU dat_ready
//  alu_instr        out  6   to ALU Instruction_from_CU
//  alu_dat1         out  32  to ALU_dat1
//  alu_dat2         out  32  to ALU_dat2
//  alu_ready        in   1   from ALU_ready
//  alu_out          in   32  from ALU_out
//  alu_flags        in   4   {ALU_err,ALU_con_met,ALU_zero,ALU_overflow}
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=1 (req 0 wins first), all outputs 0, wd_cnt=0.
//  IDLE
//   - If any req_valid: grant g by round-robin (favour !last_grant on a tie).
//   - req_ready[g]=1 combinationally; latch op/a/b into alu_instr/alu_dat1/alu_dat2 (stable until next grant).
//   - Go to ISSUE.
//  ISSUE: alu_dat_ready=1 for exactly this cycle; wd_cnt<=0; go to WAIT.
//  WAIT
//   - wd_cnt++ each cycle.
//   - alu_ready=1: capture alu_out/alu_flags into resp_*; go to RESP.
//   - Else if wd_cnt==TIMEOUT_CYCLES-1: resp_out=0, resp_flags=4'b1000; go to RESP.
//  RESP: resp_valid[g]=1 with data stable; on resp_ready[g]: last_grant<=g, go to IDLE.
//  Timing
//   - ALU sees dat_ready at the end of ISSUE. alu_ready is high in cycle ISSUE+3; resp_valid is first high at ISSUE+4.
//   - Accept to response = 5 cycles; best-case op period = 6 cycles.
//   - RESP+IDLE guarantee the ALU counter is back at 00 before the next ISSUE. Never pulse dat_ready outside ISSUE.
//  Edge cases
//   - alu_ready outside WAIT: ignored.
//   - req_valid dropped before grant: no grant; the arbiter does not check legality of a held request.
//   - Unknown op: passed through; the ALU returns NOP with zero=1.
//   - Reset mid-op: all state cleared next edge; no response emitted. The ALU shares the reset.
//   - Same-cycle alu_ready and timeout: alu_ready wins.
// STRUCTURE
//  alu_pkg
//   - localparams for ALU op codes (BEQ=4..BGEU=9, ADDI=18..ANDI=23, ADD=27..AND=36).
//   - typedef enum logic[1:0] {IDLE,ISSUE,WAIT,RESP} alu_arb_state_t.
//   - flag bit indices.
//  Sub-module rr_arb2: two-requester round-robin picker (comb), inputs req[1:0], last_grant; output onehot grant.
// TESTING
//  - Req0 ADD(27) a=5 b=7 -> req_ready[0] at T0, alu_dat_ready at T1 only, resp_valid[0] at T5, out=12, flags=0000.
//  - Both valid at T0 after reset, req0 ADD 1+1, req1 SUB(28) 9-9 -> req0 served first (out=2), then req1 (out=0, zero=1).
//  - Req1 BEQ(4) a=b=32'hDEAD_BEEF -> resp_flags con_met=1; BNE(5) same operands -> con_met=0.
//  - ALU stub never raises ready, TIMEOUT_CYCLES=8 -> resp_valid 8 cycles after ISSUE, out=0, flags=4'b1000.
//  - Reset pulsed during WAIT -> next cycle all outputs 0, state IDLE, no resp_valid; a new req is served normally.
//  - resp_ready[0] low for 10 cycles, req1 valid throughout -> resp held stable, req_ready stays 0, req1 served after release.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU arbiter slice.
//   - ALU Instruction_from_CU op codes (branches, immediate ops, register ops)
//   - alu_arb_state_t: arbiter FSM states
//   - bit positions inside the 4-bit {err,con_met,zero,overflow} flag word
package alu_pkg;

  localparam int OP_W   = 6;
  localparam int DATA_W = 32;
  localparam int FLAG_W = 4;

  // Branch / compare ops
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
  localparam logic [OP_W-1:0] OP_BNE   = 6'd5;
  localparam logic [OP_W-1:0] OP_BLT   = 6'd6;
  localparam logic [OP_W-1:0] OP_BGE   = 6'd7;
  localparam logic [OP_W-1:0] OP_BLTU  = 6'd8;
  localparam logic [OP_W-1:0] OP_BGEU  = 6'd9;

  // Immediate ops
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd18;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'd19;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'd20;
  localparam logic [OP_W-1:0] OP_XORI  = 6'd21;
  localparam logic [OP_W-1:0] OP_ORI   = 6'd22;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'd23;

  // Register-register ops
  localparam logic [OP_W-1:0] OP_ADD   = 6'd27;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd28;
  localparam logic [OP_W-1:0] OP_SLL   = 6'd29;
  localparam logic [OP_W-1:0] OP_SLT   = 6'd30;
  localparam logic [OP_W-1:0] OP_SLTU  = 6'd31;
  localparam logic [OP_W-1:0] OP_XOR   = 6'd32;
  localparam logic [OP_W-1:0] OP_SRL   = 6'd33;
  localparam logic [OP_W-1:0] OP_SRA   = 6'd34;
  localparam logic [OP_W-1:0] OP_OR    = 6'd35;
  localparam logic [OP_W-1:0] OP_AND   = 6'd36;

  // Flag word bit positions: {err, con_met, zero, overflow}
  localparam int FLAG_ERR  = 3;
  localparam int FLAG_CON  = 2;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_OVF  = 0;

  // Response flags reported when the ALU never answers
  localparam logic [FLAG_W-1:0] TIMEOUT_FLAGS = 4'b1000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} alu_arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-requester round-robin picker.
// Ports:
//   req        in  2  request vector
//   last_grant in  1  index of the requester served most recently
//   grant      out 2  one-hot grant (all zero when nothing requests)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // On a tie the requester that did not go last wins.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between CU execute (req 0) and the
// branch/compare path (req 1). One op in flight at a time; the ALU gets a
// single-cycle dat_ready pulse and the result goes back to the requester
// that was granted. A watchdog turns a hung ALU into an error response.
// Ports:
//   soc_clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready [1:0]      request handshake (ready is one-hot, IDLE only)
//   req_op*/req_a*/req_b*          op code and operands per requester
//   resp_valid/resp_ready [1:0]    response handshake (valid one-hot, held)
//   resp_out, resp_flags           result and {err,con_met,zero,overflow}
//   alu_dat_ready, alu_instr,
//   alu_dat1, alu_dat2             drive the ALU
//   alu_ready, alu_out, alu_flags  returned by the ALU
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic              soc_clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [OP_W-1:0]   req_op1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [DATA_W-1:0] resp_out,
  output logic [FLAG_W-1:0] resp_flags,
  output logic              alu_dat_ready,
  output logic [OP_W-1:0]   alu_instr,
  output logic [DATA_W-1:0] alu_dat1,
  output logic [DATA_W-1:0] alu_dat2,
  input  logic              alu_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [FLAG_W-1:0] alu_flags
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  // wd_cnt is cleared in ISSUE and reads 0 in the first WAIT cycle, so
  // expiring at TIMEOUT_CYCLES-2 puts the error response exactly
  // TIMEOUT_CYCLES cycles after ISSUE.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 2);

  alu_arb_state_t  state;
  logic            last_grant;
  logic            cur_grant;
  logic [1:0]      grant;
  logic [WD_W-1:0] wd_cnt;

  rr_arb2 u_rr_arb2 (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Accept is combinational so a request is taken in the same IDLE cycle.
  assign req_ready = (state == IDLE) ? grant : 2'b00;

  // Main FSM; every ALU-facing and response output is registered here.
  always_ff @(posedge soc_clk) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      cur_grant     <= 1'b0;
      wd_cnt        <= '0;
      alu_dat_ready <= 1'b0;
      alu_instr     <= '0;
      alu_dat1      <= '0;
      alu_dat2      <= '0;
      resp_valid    <= 2'b00;
      resp_out      <= '0;
      resp_flags    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            cur_grant     <= grant[1];
            alu_instr     <= grant[1] ? req_op1 : req_op0;
            alu_dat1      <= grant[1] ? req_a1  : req_a0;
            alu_dat2      <= grant[1] ? req_b1  : req_b0;
            alu_dat_ready <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          alu_dat_ready <= 1'b0;
          wd_cnt        <= '0;
          state         <= WAIT;
        end
        WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          // A real answer beats the watchdog when both land together.
          if (alu_ready) begin
            resp_out   <= alu_out;
            resp_flags <= alu_flags;
            resp_valid <= cur_grant ? 2'b10 : 2'b01;
            state      <= RESP;
          end else if (wd_cnt == WD_LAST) begin
            resp_out   <= '0;
            resp_flags <= TIMEOUT_FLAGS;
            resp_valid <= cur_grant ? 2'b10 : 2'b01;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready[cur_grant]) begin
            resp_valid <= 2'b00;
            last_grant <= cur_grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter. Drivers push the
// expected response of each accepted op into a queue; a negedge monitor
// checks grants, the dat_ready pulse, response timing and data against it.
// A behavioural ALU stub answers three cycles after dat_ready.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int TIMEOUT_CYCLES = 8;
  localparam int LAT_NORMAL     = 5;
  localparam int LAT_TIMEOUT    = TIMEOUT_CYCLES + 1;

  logic              soc_clk;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [OP_W-1:0]   req_op0, req_op1;
  logic [DATA_W-1:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [DATA_W-1:0] resp_out;
  logic [FLAG_W-1:0] resp_flags;
  logic              alu_dat_ready;
  logic [OP_W-1:0]   alu_instr;
  logic [DATA_W-1:0] alu_dat1, alu_dat2;
  logic              alu_ready;
  logic [DATA_W-1:0] alu_out;
  logic [FLAG_W-1:0] alu_flags;

  alu_arbiter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .soc_clk       (soc_clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op0       (req_op0),
    .req_op1       (req_op1),
    .req_a0        (req_a0),
    .req_a1        (req_a1),
    .req_b0        (req_b0),
    .req_b1        (req_b1),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_out      (resp_out),
    .resp_flags    (resp_flags),
    .alu_dat_ready (alu_dat_ready),
    .alu_instr     (alu_instr),
    .alu_dat1      (alu_dat1),
    .alu_dat2      (alu_dat2),
    .alu_ready     (alu_ready),
    .alu_out       (alu_out),
    .alu_flags     (alu_flags)
  );

  initial soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  typedef struct {
    logic              r;
    logic [DATA_W-1:0] out;
    logic [FLAG_W-1:0] flags;
    int                lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference ALU: {flags, result} from the op definitions.
  function automatic logic [FLAG_W+DATA_W-1:0] ref_alu(input logic [OP_W-1:0] op,
                                                       input logic [DATA_W-1:0] a,
                                                       input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    logic [FLAG_W-1:0] f;
    logic              arith;
    r = '0;
    f = '0;
    arith = 1'b1;
    case (op)
      OP_BEQ:  begin arith = 1'b0; f[FLAG_CON] = (a == b); end
      OP_BNE:  begin arith = 1'b0; f[FLAG_CON] = (a != b); end
      OP_BLT:  begin arith = 1'b0; f[FLAG_CON] = ($signed(a) <  $signed(b)); end
      OP_BGE:  begin arith = 1'b0; f[FLAG_CON] = ($signed(a) >= $signed(b)); end
      OP_BLTU: begin arith = 1'b0; f[FLAG_CON] = (a <  b); end
      OP_BGEU: begin arith = 1'b0; f[FLAG_CON] = (a >= b); end
      OP_ADD, OP_ADDI: begin
        r = a + b;
        f[FLAG_OVF] = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_SUB: begin
        r = a - b;
        f[FLAG_OVF] = (a[31] != b[31]) && (r[31] != a[31]);
      end
      OP_SLT, OP_SLTI:   r = {31'd0, ($signed(a) < $signed(b))};
      OP_SLTU, OP_SLTIU: r = {31'd0, (a < b)};
      OP_XOR, OP_XORI:   r = a ^ b;
      OP_OR, OP_ORI:     r = a | b;
      OP_AND, OP_ANDI:   r = a & b;
      OP_SLL:            r = a << b[4:0];
      OP_SRL:            r = a >> b[4:0];
      OP_SRA:            r = 32'($signed(a) >>> b[4:0]);
      default:           r = '0;
    endcase
    if (arith) f[FLAG_ZERO] = (r == '0);
    return {f, r};
  endfunction

  // Tie goes to the requester that was not served last.
  function automatic logic [1:0] pickGrant(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ALU stub: result appears three cycles after the ISSUE cycle.
  logic              hang;
  logic              stray_en;
  logic [1:0]        stub_cnt;
  logic [OP_W-1:0]   s_op;
  logic [DATA_W-1:0] s_a, s_b;

  always @(posedge soc_clk) begin
    alu_ready <= 1'b0;
    if (reset) begin
      stub_cnt <= 2'd0;
    end else if (alu_dat_ready) begin
      stub_cnt <= 2'd1;
      s_op     <= alu_instr;
      s_a      <= alu_dat1;
      s_b      <= alu_dat2;
    end else if (stub_cnt == 2'd1) begin
      stub_cnt <= 2'd2;
    end else if (stub_cnt == 2'd2) begin
      stub_cnt <= 2'd0;
      if (!hang) begin
        alu_ready              <= 1'b1;
        {alu_flags, alu_out}   <= ref_alu(s_op, s_a, s_b);
      end
    end else if (stray_en && !hang && $urandom_range(0, 3) == 0) begin
      alu_ready <= 1'b1;
      alu_out   <= $urandom;
      alu_flags <= 4'($urandom);
    end
  end

  // Monitor / scoreboard
  int                    cycle = 0;
  int                    accept_cycle = 0;
  logic                  busy = 1'b0;
  logic                  resp_seen = 1'b0;
  logic                  model_last = 1'b1;
  exp_t                  e_new;
  logic [FLAG_W+DATA_W-1:0] res;

  always @(negedge soc_clk) begin
    cycle++;
    if (reset) begin
      busy       = 1'b0;
      resp_seen  = 1'b0;
      model_last = 1'b1;
      exp_q.delete();
    end else begin
      checkOutput("alu_dat_ready", alu_dat_ready, busy && (cycle == accept_cycle + 1));
      checkOutput("req_ready", req_ready, busy ? 2'b00 : pickGrant(req_valid, model_last));
      if (resp_valid != 2'b00) begin
        if (!busy || exp_q.size() == 0) begin
          checkOutput("resp_unexpected", resp_valid, 2'b00);
        end else begin
          checkOutput("resp_valid", resp_valid, exp_q[0].r ? 2'b10 : 2'b01);
          checkOutput("resp_out", resp_out, exp_q[0].out);
          checkOutput("resp_flags", resp_flags, exp_q[0].flags);
          if (!resp_seen)
            checkOutput("resp_latency", cycle - accept_cycle, exp_q[0].lat);
          resp_seen = 1'b1;
          if ((resp_valid & resp_ready) != 2'b00) begin
            model_last = exp_q[0].r;
            void'(exp_q.pop_front());
            busy      = 1'b0;
            resp_seen = 1'b0;
          end
        end
      end else if (busy && exp_q.size() != 0) begin
        if (resp_seen || (cycle - accept_cycle > exp_q[0].lat)) begin
          checkOutput(resp_seen ? "resp_dropped" : "resp_missing",
                      resp_valid, exp_q[0].r ? 2'b10 : 2'b01);
          void'(exp_q.pop_front());
          busy      = 1'b0;
          resp_seen = 1'b0;
        end
      end
      if ((req_valid & req_ready) != 2'b00) begin
        e_new.r = req_ready[1];
        if (hang) begin
          e_new.out   = '0;
          e_new.flags = 4'b1000;
          e_new.lat   = LAT_TIMEOUT;
        end else begin
          res = e_new.r ? ref_alu(req_op1, req_a1, req_b1) : ref_alu(req_op0, req_a0, req_b0);
          e_new.out   = res[DATA_W-1:0];
          e_new.flags = res[FLAG_W+DATA_W-1:DATA_W];
          e_new.lat   = LAT_NORMAL;
        end
        exp_q.push_back(e_new);
        busy         = 1'b1;
        resp_seen    = 1'b0;
        accept_cycle = cycle;
      end
    end
  end

  task automatic applyStimulus(input int r, input logic [OP_W-1:0] op,
                               input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    int n = 0;
    @(posedge soc_clk);
    #1;
    if (r == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; end
    else        begin req_op1 = op; req_a1 = a; req_b1 = b; end
    req_valid[r] = 1'b1;
    do begin
      @(negedge soc_clk);
      n++;
    end while (req_ready[r] !== 1'b1 && n < 200);
    if (req_ready[r] !== 1'b1) checkOutput("req_accept", req_ready[r], 1'b1);
    @(posedge soc_clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic waitIdle(input int max_cycles);
    int n = 0;
    int run = 0;
    while (run < 2 && n < max_cycles) begin
      @(negedge soc_clk);
      n++;
      if (!busy && req_valid == 2'b00 && resp_valid == 2'b00) run++;
      else run = 0;
    end
    if (run < 2) checkOutput("wait_idle", {busy, resp_valid}, 3'b000);
  endtask

  task automatic resetDut();
    @(posedge soc_clk);
    #1 reset = 1'b1;
    @(posedge soc_clk);
    #1 reset = 1'b0;
  endtask

  task automatic checkResetState();
    checkOutput("rst_req_ready", req_ready, 2'b00);
    checkOutput("rst_resp_valid", resp_valid, 2'b00);
    checkOutput("rst_dat_ready", alu_dat_ready, 1'b0);
    checkOutput("rst_alu_instr", alu_instr, 6'd0);
    checkOutput("rst_alu_dat1", alu_dat1, 32'd0);
    checkOutput("rst_alu_dat2", alu_dat2, 32'd0);
    checkOutput("rst_resp_out", resp_out, 32'd0);
    checkOutput("rst_resp_flags", resp_flags, 4'd0);
  endtask

  int drivers_done = 0;

  task automatic randomDriver(input int r, input int count);
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge soc_clk);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      applyStimulus(r, 6'($urandom_range(0, 40)), a, b);
    end
    drivers_done++;
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 2'b00;
    req_op0    = '0; req_op1 = '0;
    req_a0     = '0; req_a1  = '0;
    req_b0     = '0; req_b1  = '0;
    resp_ready = 2'b11;
    hang       = 1'b0;
    stray_en   = 1'b0;
    repeat (3) @(posedge soc_clk);
    #1 reset = 1'b0;
    checkResetState();

    $display("[TB] single ADD on requester 0");
    applyStimulus(0, OP_ADD, 32'd5, 32'd7);
    waitIdle(50);

    $display("[TB] simultaneous requests after reset");
    resetDut();
    fork
      applyStimulus(0, OP_ADD, 32'd1, 32'd1);
      applyStimulus(1, OP_SUB, 32'd9, 32'd9);
    join
    waitIdle(50);

    $display("[TB] BEQ / BNE on requester 1");
    applyStimulus(1, OP_BEQ, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    waitIdle(50);
    applyStimulus(1, OP_BNE, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    waitIdle(50);

    $display("[TB] hung ALU watchdog");
    hang = 1'b1;
    applyStimulus(0, OP_ADD, 32'd3, 32'd4);
    waitIdle(50);
    hang = 1'b0;
    applyStimulus(1, OP_ADDI, 32'h7FFF_FFFF, 32'd1);
    waitIdle(50);

    $display("[TB] reset during WAIT");
    applyStimulus(0, OP_XOR, 32'h1234_5678, 32'h0F0F_0F0F);
    resetDut();
    checkResetState();
    applyStimulus(1, OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
    waitIdle(50);

    $display("[TB] response back-pressure with competing request");
    resp_ready = 2'b10;
    applyStimulus(0, OP_OR, 32'hA0A0_0000, 32'h0000_0505);
    fork
      applyStimulus(1, OP_SLL, 32'h0000_0003, 32'd4);
    join_none
    repeat (LAT_NORMAL + 10) @(posedge soc_clk);
    #1 resp_ready = 2'b11;
    waitIdle(100);

    $display("[TB] randomized traffic");
    stray_en = 1'b1;
    fork
      randomDriver(0, 30);
      randomDriver(1, 30);
      begin
        while (drivers_done < 2) begin
          @(posedge soc_clk);
          #1 resp_ready = 2'($urandom);
        end
      end
    join
    #1 resp_ready = 2'b11;
    waitIdle(100);
    stray_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit at cycle %0d", cycle);
    $fatal(1, "[TB] time limit reached");
  end

endmodule
